keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  Producer end of the keypad interface that the game FSM and the debug capture core consume.
//  Scans a 4x4 active-low matrix keypad and debounces it over whole scans.
//  Publishes the last accepted key code on key[4:0].
//  Emits a one-cycle keypad_pressed strobe per accepted press; this is the debug-capture trigger source.
// PARAMETERS
//  SCAN_DIV        27000  clk cycles each column is driven (1 ms at 27 MHz); >=4
//  DEBOUNCE_SCANS  10     consecutive identical full scans needed to accept a press or a release; >=2
// PORTS
//  clk             in   1  system clock; single clock domain
//  rst_n           in   1  synchronous, active-low reset
//  row_n           in   4  keypad rows, pulled up, 0 = pressed in driven column; asynchronous
//  col_n           out  4  keypad columns, one-hot active-low drive
//  key             out  5  last accepted code: {1'b0,row[1:0],col[1:0]}; 5'h10 = none since reset
//  keypad_pressed  out  1  1-cycle strobe, same cycle key updates
//  key_held        out  1  level, 1 from accept until debounced release
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge) applies these values:
//   - col_n=4'b1110; key=5'h10; keypad_pressed=0; key_held=0.
//   - Scan counters, debounce counters and the FSM clear; FSM returns to IDLE.
//   - Reset mid-press discards all partial state; no strobe is produced for that press.
//  Input sync: row_n passes through a 2-FF synchronizer before any use.
//  Column scan:
//   - Column c (0..3) is driven for SCAN_DIV cycles.
//   - Synchronized rows are sampled on the last dwell cycle, giving SCAN_DIV-3 cycles of settling.
//   - col_n then rotates left; 1110 -> 1101 -> 1011 -> 0111 -> 1110.
//  Scan result: computed once per full scan (4 columns), at the column-3 sample.
//   - Exactly one key down -> code = row*4+col.
//   - Zero keys down -> NONE.
//   - Two or more keys down (ghosting) -> MULTI; MULTI is treated as NONE.
//  Debounce FSM, evaluated once per scan result:
//   - IDLE: result k valid -> cand=k, cnt=1, go to PRESS_DB.
//   - PRESS_DB: result==cand -> cnt++.
//     - When cnt reaches DEBOUNCE_SCANS: key<=cand, keypad_pressed=1 for one cycle, key_held<=1, go to HELD.
//     - Result a different valid key -> cand=new, cnt=1 (restart).
//     - Result NONE -> IDLE.
//   - HELD: any valid key (same or different) -> rcnt=0, no new strobe. NONE -> rcnt++.
//     - When rcnt reaches DEBOUNCE_SCANS: key_held<=0, go to IDLE. key keeps its value.
//  Latency:
//   - Strobe fires DEBOUNCE_SCANS scans after the first scan in which the key is seen.
//   - Key-down to strobe is at most (DEBOUNCE_SCANS+1)*4*SCAN_DIV+2 cycles.
//  Counters:
//   - Dwell counter width $clog2(SCAN_DIV); it wraps to 0 at SCAN_DIV-1.
//   - cnt/rcnt width $clog2(DEBOUNCE_SCANS+1); they saturate and never wrap.
//  Only one strobe is produced per press-release cycle; a held key never repeats.
//  All outputs are registered; no combinational path from row_n to any output.
// STRUCTURE
//  keypad_pkg holds:
//   - kp_state_t enum {IDLE, PRESS_DB, HELD}.
//   - NO_KEY = 5'h10.
//   - ROWS = COLS = 4.
//   - Key-code localparams (e.g. KEY_0..KEY_F).
//  Sub-module keypad_debouncer implements the debounce FSM and counters, fed by a scan-result valid and code.
//  Top level holds the synchronizer, column rotation and per-scan accumulation.
// TESTING (bench uses SCAN_DIV=4, DEBOUNCE_SCANS=3; scan = 16 cycles)
//  1. Reset: rst_n=0 for 2 cycles.
//     -> col_n=1110, key=5'h10, keypad_pressed=0, key_held=0.
//     -> After release, col_n rotates every 4 cycles.
//  2. Clean press: keypad model shorts row2/col1 from scan start.
//     -> Exactly one strobe with key=5'h09, 3 scans later.
//     -> key_held=1 until 3 NONE scans after release; key stays 5'h09.
//  3. Bounce: key 5'h05 toggles every 2 scans for 10 scans, then is held.
//     -> No strobe during bouncing; one strobe 3 scans into the stable hold.
//  4. Ghosting: keys 5'h00 and 5'h05 both held.
//     -> No strobe, key unchanged.
//     -> Then release 5'h05 -> one strobe with key=5'h00.
//  5. Held key changes: hold 5'h03 until accepted, then switch to 5'h0C with no gap.
//     -> No second strobe.
//     -> After full release plus a fresh press of 5'h0C -> strobe with key=5'h0C.
//  6. Reset mid-debounce: assert rst_n=0 in PRESS_DB with cnt=2.
//     -> No strobe; outputs take reset values.
//     -> With the key still held, the strobe comes 3 scans after reset release.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
// Key codes are {1'b0, row[1:0], col[1:0]}; bit 4 set means "no key".
package keypad_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  localparam logic [4:0] NO_KEY = 5'h10;

  typedef enum logic [4:0] {
    KEY_0 = 5'h00, KEY_1 = 5'h01, KEY_2 = 5'h02, KEY_3 = 5'h03,
    KEY_4 = 5'h04, KEY_5 = 5'h05, KEY_6 = 5'h06, KEY_7 = 5'h07,
    KEY_8 = 5'h08, KEY_9 = 5'h09, KEY_A = 5'h0A, KEY_B = 5'h0B,
    KEY_C = 5'h0C, KEY_D = 5'h0D, KEY_E = 5'h0E, KEY_F = 5'h0F,
    KEY_NONE = 5'h10
  } key_code_t;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    HELD
  } kp_state_t;

  function automatic logic [4:0] key_code(input logic [1:0] row, input logic [1:0] col);
    return {1'b0, row, col};
  endfunction

endpackage

// File: rtl/keypad_if.sv
// Consumer-facing keypad interface: accepted key code, press strobe and held level.
// The scanner drives the master side; the game FSM and debug capture use the slave side.
interface keypad_if;
  logic [4:0] key;
  logic       keypad_pressed;
  logic       key_held;

  modport master (output key, keypad_pressed, key_held);
  modport slave  (input  key, keypad_pressed, key_held);
endinterface

// File: rtl/keypad_debouncer.sv
// Whole-scan debounce FSM: accepts a key after DEBOUNCE_SCANS identical scan results
// and releases it after DEBOUNCE_SCANS empty results, with one strobe per press.
module keypad_debouncer
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       res_valid,
  input  logic [4:0] res_code,
  output logic [4:0] key,
  output logic       keypad_pressed,
  output logic       key_held
);

  localparam int            CW      = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  kp_state_t     state_q, state_d;
  logic [4:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d, rcnt_q, rcnt_d;
  logic [CW-1:0] cnt_inc, rcnt_inc;
  logic          res_key;
  logic          accept, release_ev;

  // MULTI and NONE both arrive as NO_KEY, so bit 4 alone separates "no usable key".
  assign res_key  = res_valid && !res_code[4];
  assign cnt_inc  = (cnt_q  == CNT_MAX) ? cnt_q  : cnt_q  + CNT_ONE;
  assign rcnt_inc = (rcnt_q == CNT_MAX) ? rcnt_q : rcnt_q + CNT_ONE;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cand_q  <= NO_KEY;
      cnt_q   <= '0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    rcnt_d  = rcnt_q;
    if (res_valid) begin
      case (state_q)
        IDLE: begin
          if (res_key) begin
            state_d = PRESS_DB;
            cand_d  = res_code;
            cnt_d   = CNT_ONE;
          end
        end
        PRESS_DB: begin
          if (!res_key) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (res_code == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              state_d = HELD;
              rcnt_d  = '0;
            end
          end else begin
            cand_d = res_code;
            cnt_d  = CNT_ONE;
          end
        end
        HELD: begin
          if (res_key) begin
            rcnt_d = '0;
          end else begin
            rcnt_d = rcnt_inc;
            if (rcnt_inc == CNT_MAX) begin
              state_d = IDLE;
              cnt_d   = '0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    accept     = (state_q == PRESS_DB) && (state_d == HELD);
    release_ev = (state_q == HELD)     && (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key            <= NO_KEY;
      keypad_pressed <= 1'b0;
      key_held       <= 1'b0;
    end else begin
      keypad_pressed <= accept;
      if (accept) begin
        key      <= cand_q;
        key_held <= 1'b1;
      end else if (release_ev) begin
        key_held <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: synchronizes rows, rotates the column drive and
// reduces each full scan to one code that feeds the debouncer.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 27000,
  parameter int DEBOUNCE_SCANS = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  keypad_if.master   kp
);

  localparam int            DW       = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);

  logic [ROWS-1:0] row_meta, row_sync, row_dn;
  logic [DW-1:0]   div_cnt;
  logic [1:0]      col_idx;
  logic            sample;
  logic [1:0]      hits, col_hits, tot_hits;
  logic [1:0]      col_row;
  logic [2:0]      hit_sum;
  logic [4:0]      acc_code, tot_code;
  logic            res_valid;
  logic [4:0]      res_code;

  assign sample = (div_cnt == DIV_LAST);
  assign row_dn = ~row_sync;

  // Keys down in the current column; count saturates at 2, which already means MULTI.
  always_comb begin
    col_hits = '0;
    col_row  = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (row_dn[r]) begin
        col_row = 2'(r);
        if (col_hits != 2'd2) col_hits = col_hits + 2'd1;
      end
    end
  end

  always_comb begin
    hit_sum  = {1'b0, hits} + {1'b0, col_hits};
    tot_hits = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    tot_code = acc_code;
    if (col_hits == 2'd1) tot_code = key_code(col_row, col_idx);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_meta  <= '1;
      row_sync  <= '1;
      div_cnt   <= '0;
      col_idx   <= '0;
      col_n     <= 4'b1110;
      hits      <= '0;
      acc_code  <= NO_KEY;
      res_valid <= 1'b0;
      res_code  <= NO_KEY;
    end else begin
      row_meta  <= row_n;
      row_sync  <= row_meta;
      res_valid <= 1'b0;
      if (sample) begin
        div_cnt <= '0;
        col_idx <= col_idx + 2'd1;
        col_n   <= {col_n[2:0], col_n[3]};
        if (col_idx == 2'(COLS - 1)) begin
          res_valid <= 1'b1;
          res_code  <= (tot_hits == 2'd1) ? tot_code : NO_KEY;
          hits      <= '0;
          acc_code  <= NO_KEY;
        end else begin
          hits     <= tot_hits;
          acc_code <= tot_code;
        end
      end else begin
        div_cnt <= div_cnt + DIV_ONE;
      end
    end
  end

  keypad_debouncer #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debouncer (
    .clk            (clk),
    .rst_n          (rst_n),
    .res_valid      (res_valid),
    .res_code       (res_code),
    .key            (kp.key),
    .keypad_pressed (kp.keypad_pressed),
    .key_held       (kp.key_held)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a pressed-key mask drives a physical matrix model, and a
// sliding-window model of whole-scan results predicts key, strobe, held and column drive.
module tb_keypad_scanner;
  import keypad_pkg::*;

  localparam int SD   = 4;
  localparam int DB   = 3;
  localparam int SCAN = 4 * SD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  row_n, col_n;
  logic [15:0] mask = '0;

  keypad_if kp ();

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .row_n (row_n),
    .col_n (col_n),
    .kp    (kp)
  );

  always #5 clk = ~clk;

  // Physical matrix: a pressed key shorts its row low while its column is driven low.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (col_n[c] === 1'b0 && mask[r*4+c]) row_n[r] = 1'b0;
  end

  int total = 0;
  int bad   = 0;
  int strobes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state
  int         ec = 0;
  bit         active = 0;
  logic [4:0] m_key = NO_KEY;
  bit         m_held = 0, m_pressed = 0, pend = 0;
  logic [4:0] pend_code = NO_KEY;
  logic [4:0] hist [DB];
  logic [3:0] exp_col;

  function automatic logic [4:0] scan_code(input logic [15:0] m);
    logic [4:0] code = NO_KEY;
    if ($countones(m) == 1)
      for (int i = 0; i < 16; i++) if (m[i]) code = 5'(i);
    return code;
  endfunction

  // Accept when the last DB results are one valid key; release when the last DB are empty.
  task automatic apply(input logic [4:0] code);
    bit same_key = 1;
    bit all_none = 1;
    for (int i = DB - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = code;
    for (int i = 0; i < DB; i++) begin
      if (hist[i] !== hist[0] || hist[0] == NO_KEY) same_key = 0;
      if (hist[i] != NO_KEY) all_none = 0;
    end
    if (!m_held && same_key) begin
      m_held = 1; m_key = code; m_pressed = 1;
    end else if (m_held && all_none) begin
      m_held = 0;
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      ec = 0; active = 1; m_key = NO_KEY; m_held = 0; m_pressed = 0; pend = 0;
      for (int i = 0; i < DB; i++) hist[i] = NO_KEY;
    end else if (active) begin
      ec++;
      m_pressed = 0;
      if (pend) begin
        apply(pend_code);
        pend = 0;
      end
      if (ec % SCAN == 0) begin
        pend = 1;
        pend_code = scan_code(mask);
      end
    end
  end

  always @(negedge clk) begin
    if (active) begin
      exp_col = ~(4'b0001 << ((ec / SD) % 4));
      check("col_n", col_n, exp_col);
      check("key", kp.key, m_key);
      check("keypad_pressed", kp.keypad_pressed, m_pressed);
      check("key_held", kp.key_held, m_held);
      if (kp.keypad_pressed === 1'b1) strobes++;
    end
  end

  task automatic run_scans(input int n);
    repeat (n * SCAN) @(negedge clk);
  endtask

  task automatic to_boundary();
    do @(negedge clk); while (ec % SCAN != 0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check({tag, " col_n"}, col_n, 4'b1110);
    check({tag, " key"}, kp.key, NO_KEY);
    check({tag, " pressed"}, kp.keypad_pressed, 1'b0);
    check({tag, " held"}, kp.key_held, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    int s0;
    // 1. Reset and column rotation
    do_reset("rst");
    repeat (SD) @(negedge clk);
    check("rotate 1", col_n, 4'b1101);
    repeat (SD) @(negedge clk);
    check("rotate 2", col_n, 4'b1011);
    to_boundary();

    // 2. Clean press of row2/col1
    s0 = strobes;
    mask = 16'h0200;
    run_scans(3);
    @(negedge clk);
    check("t2 strobe", kp.keypad_pressed, 1'b1);
    check("t2 key", kp.key, KEY_9);
    to_boundary();
    run_scans(2);
    mask = '0;
    run_scans(3);
    check("t2 held before release", kp.key_held, 1'b1);
    @(negedge clk);
    check("t2 released", kp.key_held, 1'b0);
    check("t2 key kept", kp.key, KEY_9);
    check("t2 strobe count", strobes - s0, 1);
    to_boundary();

    // 3. Bounce, then stable hold
    s0 = strobes;
    for (int i = 0; i < 10; i++) begin
      mask = ((i / 2) % 2 == 1) ? 16'h0020 : 16'h0000;
      run_scans(1);
    end
    check("t3 no strobe bouncing", strobes - s0, 0);
    mask = 16'h0020;
    run_scans(3);
    @(negedge clk);
    check("t3 strobe", kp.keypad_pressed, 1'b1);
    check("t3 key", kp.key, KEY_5);
    to_boundary();
    mask = '0;
    run_scans(4);
    check("t3 strobe count", strobes - s0, 1);

    // 4. Ghosting
    s0 = strobes;
    mask = 16'h0021;
    run_scans(5);
    check("t4 no strobe multi", strobes - s0, 0);
    check("t4 key unchanged", kp.key, KEY_5);
    mask = 16'h0001;
    run_scans(3);
    @(negedge clk);
    check("t4 strobe", kp.keypad_pressed, 1'b1);
    check("t4 key", kp.key, KEY_0);
    to_boundary();
    mask = '0;
    run_scans(4);

    // 5. Held key changes with no gap
    s0 = strobes;
    mask = 16'h0008;
    run_scans(3);
    @(negedge clk);
    check("t5 key 3", kp.key, KEY_3);
    to_boundary();
    mask = 16'h1000;
    run_scans(5);
    check("t5 no second strobe", strobes - s0, 1);
    check("t5 key kept", kp.key, KEY_3);
    check("t5 still held", kp.key_held, 1'b1);
    mask = '0;
    run_scans(4);
    check("t5 released", kp.key_held, 1'b0);
    mask = 16'h1000;
    run_scans(3);
    @(negedge clk);
    check("t5 strobe C", kp.keypad_pressed, 1'b1);
    check("t5 key C", kp.key, KEY_C);
    to_boundary();
    mask = '0;
    run_scans(4);
    check("t5 strobe count", strobes - s0, 2);

    // 6. Reset during PRESS_DB with cnt=2
    s0 = strobes;
    mask = 16'h0020;
    run_scans(2);
    @(negedge clk);
    do_reset("t6 rst");
    check("t6 no strobe", strobes - s0, 0);
    run_scans(3);
    @(negedge clk);
    check("t6 strobe", kp.keypad_pressed, 1'b1);
    check("t6 key", kp.key, KEY_5);
    repeat (4) @(negedge clk);
    check("t6 strobe count", strobes - s0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
